// File: rtl/jogador_automatico.sv
// -----------------------------------------------------------------------------
// jogador_automatico
//
// Automatic player for the memory-sequence game. It starts a round on the
// game circuit, presents each play on `chaves` for HOLD cycles followed by a
// one-cycle zero gap, then waits for the game's verdict or a timeout.
//
// Optional feature macro: JOGADOR_ERRO_EN
//   When defined, play number ERRO_POS is presented rotated left by one bit,
//   so the game is driven down its `errou` path on purpose.
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   comecar      in   start request, looked at only when idle or finished
//   pronto       in   game finished
//   acertou      in   game won
//   errou        in   game lost
//   iniciar      out  one-cycle start pulse to the game
//   chaves[3:0]  out  switch value presented to the game
//   fim          out  round over
//   res_ok       out  round ended with a win
//   res_erro     out  round ended with a loss or an early verdict
//   res_timeout  out  no verdict within TIMEOUT cycles
//   db_jogada    out  current play index
//   db_estado    out  state code
// -----------------------------------------------------------------------------
module jogador_automatico #(
  parameter int N_JOGADAS = 16,
  parameter int HOLD      = 3,
  parameter int TIMEOUT   = 15,
  parameter int ERRO_POS  = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       comecar,
  input  logic       pronto,
  input  logic       acertou,
  input  logic       errou,
  output logic       iniciar,
  output logic [3:0] chaves,
  output logic       fim,
  output logic       res_ok,
  output logic       res_erro,
  output logic       res_timeout,
  output logic [3:0] db_jogada,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    OCIOSO    = 4'h0,
    INICIA    = 4'h1,
    APRESENTA = 4'h2,
    SOLTA     = 4'h3,
    ESPERA    = 4'h4,
    FIM_OK    = 4'hA,
    FIM_ERRO  = 4'hE,
    FIM_TMO   = 4'hF
  } estado_t;

  localparam logic [3:0] ULTIMA   = 4'(N_JOGADAS - 1);
  localparam logic [3:0] HOLD_FIM = 4'(HOLD - 1);
  localparam logic [7:0] TMO_FIM  = 8'(TIMEOUT - 1);
  localparam logic [3:0] ERRO_IDX = 4'(ERRO_POS);

`ifdef JOGADOR_ERRO_EN
  // An out-of-range position simply never matches a play.
  localparam bit INJECAO = (ERRO_POS >= 0) && (ERRO_POS < N_JOGADAS);
`else
  localparam bit INJECAO = 1'b0;
`endif

  estado_t    r_estado;
  estado_t    w_prox;
  logic [3:0] r_jogada;
  logic [3:0] w_jogada_prox;
  logic [3:0] r_hold;
  logic [3:0] w_hold_prox;
  logic [7:0] r_tmo;
  logic [7:0] w_tmo_prox;
  logic       r_comecar;
  logic       w_aceita_comecar;
  logic       w_aborta;

  function automatic logic [3:0] valor_jogada(input logic [3:0] idx);
    logic [3:0] v;
    v = 4'b0001 << idx[1:0];
    if (INJECAO && (idx == ERRO_IDX))
      v = {v[2:0], v[3]};
    return v;
  endfunction

  assign w_aceita_comecar = (r_estado == OCIOSO) || (r_estado == FIM_OK) ||
                            (r_estado == FIM_ERRO) || (r_estado == FIM_TMO);

  // Any verdict while plays are still being presented is premature.
  assign w_aborta = errou | pronto | acertou;

  always_comb begin
    w_prox        = r_estado;
    w_jogada_prox = r_jogada;
    w_hold_prox   = r_hold;
    w_tmo_prox    = r_tmo;
    case (r_estado)
      OCIOSO, FIM_OK, FIM_ERRO, FIM_TMO: begin
        if (r_comecar) begin
          w_prox        = INICIA;
          w_jogada_prox = 4'd0;
          w_hold_prox   = 4'd0;
          w_tmo_prox    = 8'd0;
        end
      end
      INICIA: begin
        w_prox      = APRESENTA;
        w_hold_prox = 4'd0;
      end
      APRESENTA: begin
        if (w_aborta)
          w_prox = FIM_ERRO;
        else if (r_hold == HOLD_FIM)
          w_prox = SOLTA;
        else
          w_hold_prox = r_hold + 4'd1;
      end
      SOLTA: begin
        if (w_aborta) begin
          w_prox = FIM_ERRO;
        end else if (r_jogada == ULTIMA) begin
          w_prox     = ESPERA;
          w_tmo_prox = 8'd0;
        end else begin
          w_prox        = APRESENTA;
          w_jogada_prox = r_jogada + 4'd1;
          w_hold_prox   = 4'd0;
        end
      end
      ESPERA: begin
        if (errou || (pronto && !acertou))
          w_prox = FIM_ERRO;
        else if (pronto)
          w_prox = FIM_OK;
        else if (r_tmo == TMO_FIM)
          w_prox = FIM_TMO;
        else
          w_tmo_prox = r_tmo + 8'd1;
      end
      default: w_prox = OCIOSO;
    endcase
  end

  // Outputs are decoded from the next state and index so they change on the
  // same edge as the state register while still coming straight from flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado    <= OCIOSO;
      r_jogada    <= 4'd0;
      r_hold      <= 4'd0;
      r_tmo       <= 8'd0;
      r_comecar   <= comecar;
      iniciar     <= 1'b0;
      chaves      <= 4'd0;
      fim         <= 1'b0;
      res_ok      <= 1'b0;
      res_erro    <= 1'b0;
      res_timeout <= 1'b0;
      db_jogada   <= 4'd0;
      db_estado   <= 4'd0;
    end else begin
      r_estado    <= w_prox;
      r_jogada    <= w_jogada_prox;
      r_hold      <= w_hold_prox;
      r_tmo       <= w_tmo_prox;
      r_comecar   <= comecar & w_aceita_comecar;
      iniciar     <= (w_prox == INICIA);
      chaves      <= (w_prox == APRESENTA) ? valor_jogada(w_jogada_prox) : 4'd0;
      fim         <= (w_prox == FIM_OK) || (w_prox == FIM_ERRO) || (w_prox == FIM_TMO);
      res_ok      <= (w_prox == FIM_OK);
      res_erro    <= (w_prox == FIM_ERRO);
      res_timeout <= (w_prox == FIM_TMO);
      db_jogada   <= (w_prox == OCIOSO) ? 4'd0 : w_jogada_prox;
      db_estado   <= w_prox;
    end
  end

endmodule

// File: tb/tb_jogador_automatico.sv
module tb_jogador_automatico;

  localparam int N  = 16;
  localparam int H  = 3;
  localparam int TO = 15;
  localparam int EP = 3;
  localparam int LP = N * (H + 1);

  logic       clock, reset, comecar, pronto, acertou, errou;
  logic       iniciar, fim, res_ok, res_erro, res_timeout;
  logic [3:0] chaves, db_jogada, db_estado;

  jogador_automatico #(
    .N_JOGADAS(N), .HOLD(H), .TIMEOUT(TO), .ERRO_POS(EP)
  ) dut (
    .clock(clock), .reset(reset), .comecar(comecar), .pronto(pronto),
    .acertou(acertou), .errou(errou), .iniciar(iniciar), .chaves(chaves),
    .fim(fim), .res_ok(res_ok), .res_erro(res_erro), .res_timeout(res_timeout),
    .db_jogada(db_jogada), .db_estado(db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h, t=%0t", nm, act, exp_v, $time);
    end
  endtask

  // Expected switch value for play p, straight from the play rules.
  function automatic int valor_esperado(input int p);
    int v;
    v = 1 << (p % 4);
`ifdef JOGADOR_ERRO_EN
    if (p == EP && EP < N) v = ((v << 1) | (v >> 3)) & 15;
`endif
    return v;
  endfunction

  // Reference model: a round is a timeline counted from the INICIA cycle
  // (t=0), presentation covers t=1..LP, waiting covers t>LP.
  int  m_fase = 0;          // 0 idle, 1 round running, 2 round finished
  int  m_t    = 0;
  int  m_res  = 0;          // 0 ok, 1 error, 2 timeout
  int  m_jog  = 0;
  bit  m_pend = 0;
  bit  m_valid = 0;
  int  e_ini, e_ch, e_fim, e_ok, e_er, e_to, e_jog, e_est;

  always @(posedge clock) begin
    int  antes, p, pos;
    bit  nova;
    antes = m_fase;
    if (reset) begin
      m_fase = 0;
      m_pend = comecar;
    end else begin
      nova = comecar && (antes != 1);
      if (m_fase != 1) begin
        if (m_pend) begin
          m_fase = 1;
          m_t    = 0;
        end
      end else if (m_t == 0) begin
        m_t = 1;
      end else if (m_t <= LP) begin
        if (errou || pronto || acertou) begin
          m_fase = 2; m_res = 1; m_jog = (m_t - 1) / (H + 1);
        end else m_t++;
      end else begin
        if (errou || (pronto && !acertou)) begin
          m_fase = 2; m_res = 1; m_jog = N - 1;
        end else if (pronto) begin
          m_fase = 2; m_res = 0; m_jog = N - 1;
        end else if (m_t - LP == TO) begin
          m_fase = 2; m_res = 2; m_jog = N - 1;
        end else m_t++;
      end
      m_pend = nova;
    end
    e_ini = 0; e_ch = 0; e_fim = 0; e_ok = 0; e_er = 0; e_to = 0; e_jog = 0; e_est = 0;
    if (m_fase == 1) begin
      if (m_t == 0) begin
        e_ini = 1; e_est = 1;
      end else if (m_t <= LP) begin
        p   = (m_t - 1) / (H + 1);
        pos = (m_t - 1) % (H + 1);
        e_jog = p;
        if (pos < H) begin e_ch = valor_esperado(p); e_est = 2; end
        else e_est = 3;
      end else begin
        e_est = 4; e_jog = N - 1;
      end
    end else if (m_fase == 2) begin
      e_fim = 1; e_jog = m_jog;
      if (m_res == 0) begin e_ok = 1; e_est = 'hA; end
      else if (m_res == 1) begin e_er = 1; e_est = 'hE; end
      else begin e_to = 1; e_est = 'hF; end
    end
    m_valid = 1;
  end

  always @(negedge clock) begin
    if (m_valid) begin
      chk("iniciar", iniciar, e_ini);
      chk("chaves", chaves, e_ch);
      chk("fim", fim, e_fim);
      chk("res_ok", res_ok, e_ok);
      chk("res_erro", res_erro, e_er);
      chk("res_timeout", res_timeout, e_to);
      chk("db_jogada", db_jogada, e_jog);
      chk("db_estado", db_estado, e_est);
    end
  end

  task automatic tick;
    @(negedge clock);
  endtask

  task automatic start_round;
    comecar = 1'b1;
    tick;
    comecar = 1'b0;
    tick;
    chk("inicio_pulso", iniciar, 1);
  endtask

  int r;

  initial begin
    reset = 1'b1; comecar = 1'b1; pronto = 1'b0; acertou = 1'b0; errou = 1'b0;
    repeat (2) tick;
    chk("rst_estado", db_estado, 0);
    chk("rst_iniciar", iniciar, 0);
    chk("rst_chaves", chaves, 0);
    chk("rst_fim", fim, 0);
    reset = 1'b0;

    // Release with comecar still high: INICIA on the next edge, one pulse.
    tick;
    chk("ini_pulso", iniciar, 1);
    chk("ini_estado", db_estado, 1);
    comecar = 1'b0;
    tick;
    chk("ini_unico", iniciar, 0);
    chk("chaves_primeira", chaves, 4'b0001);
    repeat (12) tick;
`ifdef JOGADOR_ERRO_EN
    chk("chaves_jogada3", chaves, 4'b0001);
`else
    chk("chaves_jogada3", chaves, 4'b1000);
`endif
    repeat (51) tick;
    chk("ultima_solta", db_estado, 3);
    chk("ultima_jogada", db_jogada, 15);
    tick;
    chk("espera_entrada", db_estado, 4);
    repeat (2) tick;
    pronto = 1'b1; acertou = 1'b1;
    tick;
    pronto = 1'b0; acertou = 1'b0;
    chk("vitoria_estado", db_estado, 'hA);
    chk("vitoria_ok", res_ok, 1);
    chk("vitoria_fim", fim, 1);

    // Abort during the fourth presentation.
    start_round;
    repeat (14) tick;
    chk("aborto_jogada_antes", db_jogada, 3);
    errou = 1'b1;
    tick;
    errou = 1'b0;
    chk("aborto_estado", db_estado, 'hE);
    chk("aborto_chaves", chaves, 0);
    chk("aborto_erro", res_erro, 1);
    chk("aborto_jogada", db_jogada, 3);

    // Timeout with pronto held low.
    start_round;
    repeat (79) tick;
    chk("tmo_ainda_espera", db_estado, 4);
    tick;
    chk("tmo_estado", db_estado, 'hF);
    chk("tmo_flag", res_timeout, 1);
    chk("tmo_ok", res_ok, 0);

    // Simultaneous verdict: errou wins over acertou.
    start_round;
    repeat (66) tick;
    pronto = 1'b1; acertou = 1'b1; errou = 1'b1;
    tick;
    pronto = 1'b0; acertou = 1'b0; errou = 1'b0;
    chk("simult_estado", db_estado, 'hE);
    chk("simult_erro", res_erro, 1);
    start_round;
    chk("replay_fim", fim, 0);
    chk("replay_erro", res_erro, 0);
    tick;
    chk("replay_chaves", chaves, 4'b0001);

    // Randomized play: starts, verdicts at random times, rare resets.
    for (int i = 0; i < 4000; i++) begin
      reset   = ($urandom_range(0, 399) == 0);
      comecar = ($urandom_range(0, 15) == 0);
      r = $urandom_range(0, 199);
      pronto  = (r < 3);
      acertou = (r < 3) ? $urandom_range(0, 1) == 1 : (r == 3);
      errou   = (r < 3) ? ($urandom_range(0, 2) == 0) : 1'b0;
      tick;
    end
    reset = 1'b0; comecar = 1'b0; pronto = 1'b0; acertou = 1'b0; errou = 1'b0;
    repeat (3) tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
